// File: rtl/encoder_pkg.sv
// Shared types and helpers for the one-hot encoder/serializer.
// Helper functions operate on a MAX_BITS-wide vector so any WIDTH up to MAX_WIDTH can use them.
package encoder_pkg;

   typedef enum logic {IDLE, BUSY} enc_state_t;

   localparam int DEFAULT_WIDTH = 3;
   localparam int MAX_WIDTH     = 8;
   localparam int MAX_BITS      = 2 ** MAX_WIDTH;

   // Lowest set-bit index; returns 0 for an all-zero vector.
   function automatic logic [MAX_WIDTH-1:0] lsb_index(input logic [MAX_BITS-1:0] vec);
      logic [MAX_WIDTH-1:0] idx;
      idx = '0;
      for (int i = MAX_BITS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = MAX_WIDTH'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic is_onehot(input logic [MAX_BITS-1:0] vec);
      return (vec != '0) && ((vec & (vec - MAX_BITS'(1))) == '0);
   endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational LSB-first priority encoder: 2**WIDTH-bit vector to WIDTH-bit index plus any-set flag.
module prio_enc_lsb
   import encoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [2**WIDTH-1:0] vec,
   output logic [WIDTH-1:0]    idx,
   output logic                any
);

   always_comb begin
      idx = WIDTH'(lsb_index(MAX_BITS'(vec)));
      any = |vec;
   end

endmodule

// File: rtl/onehot_encoder_serializer.sv
// Serializes every set bit of a request vector into one index per ready/valid beat, lowest first.
// An accepted all-zero vector is dropped and flagged with a single-cycle zero_drop pulse.
module onehot_encoder_serializer
   import encoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2**WIDTH-1:0] in_vec,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_idx,
   output logic               out_last,
   output logic               zero_drop
);

   localparam int N = 2 ** WIDTH;

   enc_state_t       state_q, state_d;
   logic [N-1:0]     pending_q, pending_d;
   logic [WIDTH-1:0] out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             zero_drop_q, zero_drop_d;

   logic [N-1:0]     cleared;
   logic [WIDTH-1:0] in_lsb, clr_lsb;
   logic             in_any, clr_any;
   logic             accept, out_hs;

   assign cleared = pending_q & (pending_q - N'(1));

   prio_enc_lsb #(.WIDTH(WIDTH)) u_enc_in (
      .vec (in_vec),
      .idx (in_lsb),
      .any (in_any)
   );

   prio_enc_lsb #(.WIDTH(WIDTH)) u_enc_clr (
      .vec (cleared),
      .idx (clr_lsb),
      .any (clr_any)
   );

   assign out_valid = (state_q == BUSY);
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign zero_drop = zero_drop_q;

   // Ready also on the final beat's handshake so the next vector follows with no bubble.
   assign out_hs   = out_valid && out_ready;
   assign in_ready = (state_q == IDLE) || (out_hs && out_last_q);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      zero_drop_d = 1'b0;

      if (accept) begin
         if (in_any) begin
            state_d    = BUSY;
            pending_d  = in_vec;
            out_idx_d  = in_lsb;
            out_last_d = is_onehot(MAX_BITS'(in_vec));
         end else begin
            state_d     = IDLE;
            pending_d   = '0;
            zero_drop_d = 1'b1;
         end
      end else if (out_hs) begin
         if (!out_last_q && clr_any) begin
            pending_d  = cleared;
            out_idx_d  = clr_lsb;
            out_last_d = is_onehot(MAX_BITS'(cleared));
         end else begin
            state_d   = IDLE;
            pending_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         zero_drop_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         zero_drop_q <= zero_drop_d;
      end
   end

endmodule

// File: tb/tb_onehot_encoder_serializer.sv
// Scoreboard bench for onehot_encoder_serializer: directed vectors push hand-computed beats,
// a negedge monitor pops and compares every output handshake.
module tb_onehot_encoder_serializer;

   localparam int WIDTH = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_vec;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic       out_last;
   logic       zero_drop;

   logic [3:0] sb[$];
   int         check_count = 0;
   int         pass_count  = 0;
   int         cyc         = 0;
   int         last_hs_cyc = 0;
   int         hs_gap      = 0;

   onehot_encoder_serializer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .zero_drop (zero_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic pushExpect(input logic [2:0] idx, input logic last);
      sb.push_back({last, idx});
   endtask

   // Presents a vector and holds in_valid until the DUT accepts it; returns 1ns after the accepting edge.
   task automatic applyStimulus(input logic [7:0] vec);
      logic accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      in_vec   = vec;
      for (int k = 0; k < 50 && !accepted; k++) begin
         @(negedge clk);
         if (in_ready) accepted = 1'b1;
      end
      checkOutput("accept", 32'(accepted), 32'd1);
      if (accepted) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic goIdle();
      in_valid = 1'b0;
      in_vec   = 8'h5A;
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
      checkOutput("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: in_ready rule every cycle, scoreboard pop on every output handshake.
   always @(negedge clk) begin
      logic [3:0] exp;
      if (rst_n) begin
         checkOutput("in_ready", 32'(in_ready), 32'(!out_valid || (out_ready && out_last)));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_count++;
               $display("[TB] FAIL unexpected_beat: got idx %0d last %0b, expected no beat", out_idx, out_last);
            end else begin
               exp = sb.pop_front();
               checkOutput("beat_idx", 32'(out_idx), 32'(exp[2:0]));
               checkOutput("beat_last", 32'(out_last), 32'(exp[3]));
            end
            hs_gap      = cyc - last_hs_cyc;
            last_hs_cyc = cyc;
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = 8'h00;
      out_ready = 1'b1;

      repeat (2) @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_idx", 32'(out_idx), 32'd0);
      checkOutput("rst_out_last", 32'(out_last), 32'd0);
      checkOutput("rst_zero_drop", 32'(zero_drop), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
      checkOutput("idle_zero_drop", 32'(zero_drop), 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] multi-bit vector 8'b1010_0110");
      pushExpect(3'd1, 1'b0);
      pushExpect(3'd2, 1'b0);
      pushExpect(3'd5, 1'b0);
      pushExpect(3'd7, 1'b1);
      applyStimulus(8'hA6);
      goIdle();
      drain();
      checkOutput("multi_gap", 32'(hs_gap), 32'd1);

      $display("[TB] backpressure 8'b1000_0001");
      out_ready = 1'b0;
      pushExpect(3'd0, 1'b0);
      pushExpect(3'd7, 1'b1);
      applyStimulus(8'h81);
      goIdle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_out_idx", 32'(out_idx), 32'd0);
         checkOutput("bp_out_last", 32'(out_last), 32'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      $display("[TB] back-to-back 8'hFF then 8'h10");
      for (int i = 0; i < 8; i++) pushExpect(3'(i), i == 7);
      pushExpect(3'd4, 1'b1);
      applyStimulus(8'hFF);
      applyStimulus(8'h10);
      goIdle();
      drain();
      checkOutput("b2b_gap", 32'(hs_gap), 32'd1);

      $display("[TB] zero vector then 8'h01");
      applyStimulus(8'h00);
      goIdle();
      @(negedge clk);
      checkOutput("zero_drop_pulse", 32'(zero_drop), 32'd1);
      checkOutput("zero_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      checkOutput("zero_drop_clear", 32'(zero_drop), 32'd0);
      checkOutput("zero_still_idle", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      pushExpect(3'd0, 1'b1);
      applyStimulus(8'h01);
      goIdle();
      drain();

      $display("[TB] mid-operation reset on 8'hF0");
      pushExpect(3'd4, 1'b0);
      pushExpect(3'd5, 1'b0);
      applyStimulus(8'hF0);
      goIdle();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mrst_out_idx", 32'(out_idx), 32'd0);
      checkOutput("mrst_out_last", 32'(out_last), 32'd0);
      checkOutput("mrst_zero_drop", 32'(zero_drop), 32'd0);
      checkOutput("mrst_sb_consumed", 32'(sb.size()), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("post_rst_no_valid", 32'(out_valid), 32'd0);
      end
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
